// File: rtl/pc_xfer_pkg.sv
// Shared types and constants for the frame-to-UART transfer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_xfer_pkg;

    // Controller phases; 3-bit encoding.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_SEND_HI  = 3'd4,
        S_SEND_LO  = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // Sync byte that precedes every frame on the UART.
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    // Pixel width: {r[3:0], g[3:0], b[3:0]}.
    localparam int PIX_W = 12;

endpackage

// File: rtl/pc_xfer_ctrl.sv
// Streams one frame from pixel BRAM to the UART: header byte, then hi/lo byte per pixel.
// Latency: header offered 1 cycle after start; each pixel costs 1 + RD_LAT cycles of read before its bytes.
// Backpressure: tx_valid/tx_data hold until tx_ready; no read is issued until the previous pixel's low byte is taken.
module pc_xfer_ctrl
    import pc_xfer_pkg::*;
#(
    parameter int         ADDR_W     = 17,
    parameter int         NUM_PIXELS = 76800,
    parameter int         RD_LAT     = 2,
    parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [PIX_W-1:0]  bram_dout,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [1:0]        LAT_MAX   = 2'(RD_LAT - 1);

    state_t           state;
    logic [1:0]       wait_cnt;
    logic [PIX_W-1:0] pix;
    logic             abort_q;

    logic             tx_hs;
    logic             abort_hit;

    // A byte leaves when the UART takes it; a pending abort takes effect only at that point.
    assign tx_hs     = tx_valid && tx_ready;
    assign abort_hit = abort || abort_q;

    // Transfer sequencer: every output is a register updated on the transition into the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 2'd0;
            pix       <= '0;
            abort_q   <= 1'b0;
            bram_addr <= '0;
            bram_en   <= 1'b0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Read enable is a single-cycle pulse unless re-armed below.
            bram_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    abort_q <= 1'b0;
                    if (abort) begin
                        // Abort beats a coincident start and only clears status.
                        done <= 1'b0;
                    end else if (start) begin
                        state     <= S_HDR;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        bram_addr <= '0;
                        tx_valid  <= 1'b1;
                        tx_data   <= HDR_BYTE;
                    end
                end

                S_HDR: begin
                    if (tx_hs) begin
                        // Header is never followed back-to-back by a byte: the first read comes first.
                        tx_valid <= 1'b0;
                        if (abort_hit) begin
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                            abort_q <= 1'b0;
                        end else begin
                            state   <= S_RD_ISSUE;
                            bram_en <= 1'b1;
                        end
                    end else if (abort) begin
                        abort_q <= 1'b1;
                    end
                end

                S_RD_ISSUE: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= S_RD_WAIT;
                        wait_cnt <= 2'd0;
                    end
                end

                S_RD_WAIT: begin
                    if (abort) begin
                        // Read data still in the BRAM pipeline is simply never captured.
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (wait_cnt == LAT_MAX) begin
                        pix      <= bram_dout;
                        state    <= S_SEND_HI;
                        tx_valid <= 1'b1;
                        tx_data  <= {4'h0, bram_dout[11:8]};
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end

                S_SEND_HI: begin
                    if (tx_hs) begin
                        if (abort_hit) begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            abort_q  <= 1'b0;
                            tx_valid <= 1'b0;
                        end else begin
                            // Low byte follows immediately; tx_valid stays up.
                            state   <= S_SEND_LO;
                            tx_data <= pix[7:0];
                        end
                    end else if (abort) begin
                        abort_q <= 1'b1;
                    end
                end

                S_SEND_LO: begin
                    if (tx_hs) begin
                        tx_valid <= 1'b0;
                        if (abort_hit) begin
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                            abort_q <= 1'b0;
                        end else if (bram_addr == LAST_ADDR) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_RD_ISSUE;
                            bram_addr <= bram_addr + ADDR_ONE;
                            bram_en   <= 1'b1;
                        end
                    end else if (abort) begin
                        abort_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    // Still busy during this cycle, so a start here is ignored.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= !abort;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_xfer_ctrl.sv
// Scoreboard bench for pc_xfer_ctrl with a 4-pixel frame and RD_LAT=2.
// Latency: n/a.
// Backpressure: tx_ready driven always-high, every-5th-cycle, random, or by an accept limit.
module tb_pc_xfer_ctrl;

    localparam int         ADDR_W = 17;
    localparam int         NP     = 4;
    localparam int         LAT    = 2;
    localparam logic [7:0] HDR    = 8'hA5;
    localparam int         NBYTES = 1 + 2 * NP;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic [11:0]       bram_dout;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    pc_xfer_ctrl #(
        .ADDR_W     (ADDR_W),
        .NUM_PIXELS (NP),
        .RD_LAT     (LAT),
        .HDR_BYTE   (HDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_dout (bram_dout),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- BRAM model: data appears LAT cycles after the enable cycle
    logic [11:0] mem [NP];
    logic [11:0] pipe_dat [LAT];
    logic        pipe_vld [LAT];

    always @(posedge clk) begin
        pipe_vld[0] <= bram_en;
        pipe_dat[0] <= mem[bram_addr[1:0]];
        for (int i = 1; i < LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
        end
    end
    assign bram_dout = pipe_vld[LAT-1] ? pipe_dat[LAT-1] : 12'hE57;

    // ---------------- tx_ready driver
    int rdy_mode  = 0;   // 0 high, 1 every 5th cycle, 2 accept-limit, 3 random
    int rdy_limit = 0;
    int cyc       = 0;
    int hs_cnt    = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 5 == 0);
            2:       tx_ready = (hs_cnt < rdy_limit);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- scoreboard / monitor
    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] en_log[$];
    logic              prev_stall = 1'b0;
    logic [7:0]        prev_dat   = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (!tx_valid || tx_data != prev_dat) begin
                    bad++;
                    $display("FAIL tx_hold: valid=%0b data=%h, required valid=1 data=%h", tx_valid, tx_data, prev_dat);
                end
            end
            if (bram_en) begin
                en_log.push_back(bram_addr);
                total++;
                if (bram_addr >= ADDR_W'(NP)) begin
                    bad++;
                    $display("FAIL addr_range: addr=%0d, required < %0d", bram_addr, NP);
                end
            end
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_byte: got %h, required no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data != e) begin
                        bad++;
                        $display("FAIL byte: got %h, required %h", tx_data, e);
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_dat   = tx_data;
        end
    end

    // ---------------- helpers
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: a frame is the header then each pixel as {0,r} and {g,b}.
    task automatic push_frame();
        exp_q.push_back(HDR);
        for (int i = 0; i < NP; i++) begin
            exp_q.push_back({4'h0, mem[i][11:8]});
            exp_q.push_back(mem[i][7:0]);
        end
    endtask

    task automatic wait_hs(input int target, input string name);
        int n = 0;
        while (hs_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        if (hs_cnt < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: handshakes=%0d, required %0d", name, hs_cnt, target);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reads(input int base, input string name);
        chk({name, "_en_count"}, en_log.size() - base, NP);
        if (en_log.size() - base == NP)
            for (int i = 0; i < NP; i++)
                chk({name, "_en_addr"}, 32'(en_log[base + i]), i);
    endtask

    task automatic run_frame(input int mode, input string name);
        int hb;
        int eb;
        rdy_mode = mode;
        push_frame();
        hb = hs_cnt;
        eb = en_log.size();
        pulse_start();
        wait_hs(hb + NBYTES, name);
        tick();
        chk({name, "_done"}, done, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        check_reads(eb, name);
    endtask

    // ---------------- stimulus
    initial begin
        int hb;
        int eb;
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            pipe_vld[i] = 1'b0;
            pipe_dat[i] = '0;
        end
        mem[0] = 12'hABC; mem[1] = 12'h123; mem[2] = 12'h0F0; mem[3] = 12'hFFF;
        tick(); tick();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick(); tick();

        // 1: ready tied high
        run_frame(0, "t1");

        // 2: ready every 5th cycle
        run_frame(1, "t2");

        // 3: abort while pixel-1 high byte is stalled
        rdy_mode  = 2;
        hb        = hs_cnt;
        rdy_limit = hb + 3;
        exp_q.push_back(HDR);
        exp_q.push_back({4'h0, mem[0][11:8]});
        exp_q.push_back(mem[0][7:0]);
        exp_q.push_back({4'h0, mem[1][11:8]});
        pulse_start();
        chk("t3_done_cleared", done, 0);
        wait_hs(hb + 3, "t3");
        n = 0;
        while (!tx_valid && n < 50) begin tick(); n++; end
        chk("t3_stalled_byte", {tx_valid, tx_data}, {1'b1, 8'h01});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(); tick();
        rdy_limit = hb + 100;
        for (int i = 0; i < 30; i++) tick();
        chk("t3_bytes", hs_cnt - hb, 4);
        chk("t3_busy", busy, 0);
        chk("t3_done", done, 0);
        chk("t3_queue_left", exp_q.size(), 0);

        // 4: abort during the read wait of pixel 2, then a fresh frame
        rdy_mode = 0;
        hb = hs_cnt;
        for (int i = 0; i < 5; i++) exp_q.push_back(i == 0 ? HDR : (i % 2 == 1) ? {4'h0, mem[i/2][11:8]} : mem[(i-1)/2][7:0]);
        pulse_start();
        n = 0;
        while (!(bram_en && bram_addr == ADDR_W'(2)) && n < 200) begin tick(); n++; end
        chk("t4_reached_rd2", {31'd0, bram_en}, 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_busy_after_abort", busy, 0);
        chk("t4_tx_valid_after_abort", tx_valid, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("t4_bytes", hs_cnt - hb, 5);
        chk("t4_done", done, 0);
        run_frame(0, "t4b");

        // 5: start hammered during the frame, including the DONE cycle
        rdy_mode = 1;
        push_frame();
        hb = hs_cnt;
        eb = en_log.size();
        pulse_start();
        n = 0;
        while (n < 3000) begin
            tick();
            n++;
            if (done) begin
                start = 1'b0;
                break;
            end else if (hs_cnt >= hb + NBYTES) begin
                start = 1'b1;
            end else begin
                start = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t5_bytes", hs_cnt - hb, NBYTES);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 1);
        check_reads(eb, "t5");

        // 6: asynchronous reset while the pixel-0 low byte is stalled
        rdy_mode  = 2;
        hb        = hs_cnt;
        rdy_limit = hb + 2;
        exp_q.push_back(HDR);
        exp_q.push_back({4'h0, mem[0][11:8]});
        pulse_start();
        wait_hs(hb + 2, "t6");
        tick(); tick();
        chk("t6_stalled_lo", {tx_valid, tx_data}, {1'b1, mem[0][7:0]});
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_tx_valid", tx_valid, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_done", done, 0);
        chk("t6_async_addr", bram_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_frame(0, "t6b");

        // random pixel data with random backpressure
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NP; i++) mem[i] = 12'($urandom);
            run_frame(3, "rnd");
        end

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
